// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared widths and FSM state encoding for the hazard controller
package pipe_hazard_ctrl_pkg;
  localparam int REG_W = 3;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2, FLUSH = 2'd3} state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline stage status in, pipeline register controls out
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;
  logic id_valid;
  logic [REG_W-1:0] id_ra;
  logic [REG_W-1:0] id_rb;
  logic id_uses_rb;
  logic ex_regwrite;
  logic ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic flush_req;
  logic mem_busy;
  logic pc_en;
  logic ifid_en;
  logic idex_en;
  logic ifid_flush;
  logic idex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0] state_o;
  modport slave (
    input id_valid, id_ra, id_rb, id_uses_rb, ex_regwrite, ex_memread, ex_rd, flush_req, mem_busy,
    output pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, stall_cnt, flush_cnt, state_o
  );
  modport master (
    output id_valid, id_ra, id_rb, id_uses_rb, ex_regwrite, ex_memread, ex_rd, flush_req, mem_busy,
    input pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, stall_cnt, flush_cnt, state_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones, async cleared
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble control for a 5-stage pipeline
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input logic clk1,
  input logic rst_n,
  pipe_hazard_ctrl_if.slave hz
);
  localparam logic [1:0] S_INIT = INIT;
  localparam logic [1:0] S_RUN = RUN;
  localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] S_FLUSH = FLUSH;
  logic [1:0] st, nst;
  logic load_use, init, run, mw, fl, run_f, run_m, run_l, run_n, fetch_en;
  always_comb begin
    load_use = hz.id_valid & hz.ex_memread & hz.ex_regwrite &
               ((hz.ex_rd == hz.id_ra) | (hz.id_uses_rb & (hz.ex_rd == hz.id_rb)));
    init = st == S_INIT;
    run = st == S_RUN;
    mw = st == S_MEM_WAIT;
    fl = st == S_FLUSH;
    run_f = run & hz.flush_req;
    run_m = run & ~hz.flush_req & hz.mem_busy;
    run_l = run & ~hz.flush_req & ~hz.mem_busy & load_use;
    run_n = run & ~hz.flush_req & ~hz.mem_busy & ~load_use;
    fetch_en = run_f | run_n | fl;
    hz.pc_en = fetch_en;
    hz.ifid_en = fetch_en;
    hz.idex_en = fetch_en | run_l;
    hz.ifid_flush = run_f;
    hz.idex_bubble = init | run_f | run_l | fl;
    nst = run_f ? S_FLUSH : (run_m | (mw & hz.mem_busy)) ? S_MEM_WAIT : S_RUN;
  end
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) st <= S_INIT;
    else st <= nst;
  assign hz.state_o = st;
  sat_counter #(.W(CNT_W)) u_stall (
    .clk1(clk1), .rst_n(rst_n), .inc(run_m | run_l | mw), .q(hz.stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk1(clk1), .rst_n(rst_n), .inc(run_f), .q(hz.flush_cnt)
  );
endmodule
